// File: rtl/uart_pkg.sv
// Shared constants, FSM encodings and helpers for the UART loopback buffer.
package uart_pkg;

    localparam int unsigned CLK_FREQ  = 50_000_000;
    localparam int unsigned UART_BPS  = 115_200;
    localparam int unsigned BAUD_CNT  = CLK_FREQ / UART_BPS;
    localparam int unsigned BAUD_HALF = BAUD_CNT / 2;

    typedef enum logic [1:0] {
        RxIdle  = 2'd0,
        RxStart = 2'd1,
        RxData  = 2'd2,
        RxStop  = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        TxIdle  = 2'd0,
        TxStart = 2'd1,
        TxData  = 2'd2,
        TxStop  = 2'd3
    } tx_state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO, 8-bit entries. Writes while full are dropped.
module sync_fifo #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);
    import uart_pkg::*;

    localparam int unsigned AddrW = clog2(FIFO_DEPTH);
    localparam logic [AddrW:0] PtrOne = 1;

    // Extra MSB on each pointer distinguishes full from empty on wrap.
    logic [AddrW:0] wr_ptr_q;
    logic [AddrW:0] rd_ptr_q;
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic           wr_ok;
    logic           rd_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q[AddrW-1:0]];

    // Storage array; no reset needed since empty masks stale entries.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= wr_data;
        end
    end

    // Pointer update; simultaneous read and write leaves occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

endmodule

// File: rtl/uart_fifo_loop.sv
// UART loopback: 8N1 receiver -> FIFO -> 8N1 transmitter at one baud rate.
module uart_fifo_loop #(
    parameter int unsigned CLK_FREQ   = uart_pkg::CLK_FREQ,
    parameter int unsigned UART_BPS   = uart_pkg::UART_BPS,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic uart_rxd,
    output logic uart_txd
);
    import uart_pkg::*;

    localparam int unsigned BaudCnt  = CLK_FREQ / UART_BPS;
    localparam int unsigned BaudHalf = BaudCnt / 2;
    localparam int unsigned CntW     = clog2(BaudCnt);
    localparam logic [CntW-1:0] CntHalf = CntW'(BaudHalf);
    localparam logic [CntW-1:0] CntLast = CntW'(BaudCnt - 1);
    localparam logic [CntW-1:0] CntOne  = 1;

    // [0],[1] synchronize; [2] is the previous synced value for edge detect.
    logic [2:0]      rxd_sync_q;
    logic            rxd_s;
    logic            rx_fall;

    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_done;
    logic            rx_sample;

    tx_state_e       tx_state_q, tx_state_d;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            txd_d;
    logic            tx_bit_end;

    logic            fifo_wr;
    logic            fifo_rd;
    logic [7:0]      fifo_rdata;
    logic            fifo_full;
    logic            fifo_empty;

    assign rxd_s      = rxd_sync_q[1];
    assign rx_fall    = rxd_sync_q[2] && !rxd_sync_q[1];
    assign rx_sample  = (rx_cnt_q == CntHalf);
    assign tx_bit_end = (tx_cnt_q == CntLast);
    assign fifo_wr    = rx_done && !fifo_full;

    // Input synchronizer; resets to idle-high so reset release is not a start edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) rxd_sync_q <= 3'b111;
        else            rxd_sync_q <= {rxd_sync_q[1:0], uart_rxd};
    end

    // RX next-state: sample each bit at mid-point, accept byte only on a high stop bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_data_d  = rx_data_q;
        rx_done    = 1'b0;
        if (rx_state_q != RxIdle) begin
            rx_cnt_d = (rx_cnt_q == CntLast) ? '0 : rx_cnt_q + CntOne;
        end
        unique case (rx_state_q)
            RxIdle: begin
                if (rx_fall) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                end
            end
            RxStart: begin
                if (rx_sample) begin
                    rx_state_d = rxd_s ? RxIdle : RxData;
                    rx_bit_d   = '0;
                end
            end
            RxData: begin
                if (rx_sample) begin
                    rx_data_d = {rxd_s, rx_data_q[7:1]};
                    rx_bit_d  = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                end
            end
            RxStop: begin
                // Leave at mid stop bit so the following start edge is not missed.
                if (rx_sample) begin
                    rx_state_d = RxIdle;
                    rx_done    = rxd_s;
                end
            end
        endcase
    end

    // RX state registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_data_q  <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_data_q  <= rx_data_d;
        end
    end

    sync_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .wr_en   (fifo_wr),
        .wr_data (rx_data_q),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // TX next-state: pop head in IDLE, then shift out start, 8 data, stop.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        fifo_rd    = 1'b0;
        txd_d      = 1'b1;
        if (tx_state_q != TxIdle) begin
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + CntOne;
        end
        unique case (tx_state_q)
            TxIdle: begin
                if (!fifo_empty) begin
                    fifo_rd    = 1'b1;
                    tx_shift_d = fifo_rdata;
                    tx_state_d = TxStart;
                    tx_cnt_d   = '0;
                end
            end
            TxStart: begin
                if (tx_bit_end) begin
                    tx_state_d = TxData;
                    tx_bit_d   = '0;
                end
            end
            TxData: begin
                if (tx_bit_end) begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TxStop;
                end
            end
            TxStop: begin
                if (tx_bit_end) tx_state_d = TxIdle;
            end
        endcase
        // Line level follows the next state so the output flop is glitch-free.
        unique case (tx_state_d)
            TxStart: txd_d = 1'b0;
            TxData:  txd_d = tx_shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    // TX state registers; line returns high the instant reset asserts.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            uart_txd   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            uart_txd   <= txd_d;
        end
    end

endmodule

// File: tb/tb_uart_fifo_loop.sv
// Directed bench: full-rate instance for timing-exact checks, fast-baud instance for
// burst and overflow sequences.
module tb_uart_fifo_loop;
    import uart_pkg::*;

    localparam int SlowBit = 434;  // 50 MHz / 115200, truncated
    localparam int FastBit = 20;   // 50 MHz / 2.5 Mbaud

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic rst_n_fast = 1'b1;
    logic rxd = 1'b1;
    logic rxd_fast = 1'b1;
    logic txd;
    logic txd_fast;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_stop_cyc = 0;
    int max_occ = 0;
    bit occ_mon = 1'b0;
    logic [4:0] occ;

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_fifo_loop dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .uart_rxd  (rxd),
        .uart_txd  (txd)
    );

    uart_fifo_loop #(
        .CLK_FREQ   (50_000_000),
        .UART_BPS   (2_500_000),
        .FIFO_DEPTH (16)
    ) dut_fast (
        .sys_clk   (clk),
        .sys_rst_n (rst_n_fast),
        .uart_rxd  (rxd_fast),
        .uart_txd  (txd_fast)
    );

    assign occ = dut_fast.u_fifo.wr_ptr_q - dut_fast.u_fifo.rd_ptr_q;

    always @(negedge clk) begin
        if (occ_mon && int'(occ) > max_occ) max_occ <= int'(occ);
    end

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic line(input bit fast);
        return fast ? txd_fast : txd;
    endfunction

    task automatic send_frame(input bit fast, input logic [7:0] d, input logic stop_bit,
                              input int idle_clks);
        int bit_clks;
        logic [9:0] frame;
        bit_clks = fast ? FastBit : SlowBit;
        frame = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (i == 9) last_stop_cyc = cyc;
            if (fast) rxd_fast = frame[i];
            else      rxd = frame[i];
            repeat (bit_clks) @(negedge clk);
        end
        if (fast) rxd_fast = 1'b1;
        else      rxd = 1'b1;
        repeat (idle_clks) @(negedge clk);
    endtask

    task automatic wait_fall(input bit fast, input int timeout, output bit got, output int t);
        int waited;
        waited = 0;
        while (line(fast) !== 1'b0 && waited < timeout) begin
            @(negedge clk);
            waited++;
        end
        got = (line(fast) === 1'b0);
        t = cyc;
    endtask

    // Decodes one frame at bit mid-points; returns at the middle of the stop bit.
    task automatic recv_frame(input bit fast, input int timeout, output logic [7:0] d,
                              output bit got, output bit ok, output int t);
        int bit_clks;
        logic s_start;
        logic s_stop;
        bit_clks = fast ? FastBit : SlowBit;
        d = '0;
        ok = 1'b0;
        wait_fall(fast, timeout, got, t);
        if (!got) return;
        repeat (bit_clks / 2) @(negedge clk);
        s_start = line(fast);
        for (int i = 0; i < 8; i++) begin
            repeat (bit_clks) @(negedge clk);
            d[i] = line(fast);
        end
        repeat (bit_clks) @(negedge clk);
        s_stop = line(fast);
        ok = (s_start === 1'b0) && (s_stop === 1'b1);
    endtask

    typedef struct {
        bit         fast;
        logic [7:0] data;
        logic       stop;
        bit         echo;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0] d;
        bit got;
        bit ok;
        int t;
        int t_prev;
        int errs;
        int gap_bad;
        logic [9:0] frame;
        logic [7:0] rx_bytes [16];

        vecs[0] = '{fast: 1'b0, data: 8'h55, stop: 1'b0, echo: 1'b0};
        vecs[1] = '{fast: 1'b0, data: 8'h42, stop: 1'b1, echo: 1'b1};
        vecs[2] = '{fast: 1'b1, data: 8'h00, stop: 1'b1, echo: 1'b1};
        vecs[3] = '{fast: 1'b1, data: 8'hFF, stop: 1'b1, echo: 1'b1};
        vecs[4] = '{fast: 1'b1, data: 8'hA5, stop: 1'b1, echo: 1'b1};
        vecs[5] = '{fast: 1'b1, data: 8'h3C, stop: 1'b0, echo: 1'b0};
        vecs[6] = '{fast: 1'b1, data: 8'h5A, stop: 1'b1, echo: 1'b1};

        // Reset, 200 ns low
        #2;
        rst_n = 1'b0;
        rst_n_fast = 1'b0;
        #1;
        check("reset_txd_immediate", {31'd0, txd}, 32'd1);
        repeat (10) @(negedge clk);
        check("reset_txd_held", {31'd0, txd}, 32'd1);
        check("reset_fifo_empty_held", {31'd0, dut.u_fifo.empty}, 32'd1);
        rst_n = 1'b1;
        rst_n_fast = 1'b1;
        repeat (20) @(negedge clk);
        check("post_reset_txd", {31'd0, txd}, 32'd1);
        check("post_reset_txd_fast", {31'd0, txd_fast}, 32'd1);
        check("post_reset_fifo_empty", {31'd0, dut.u_fifo.empty}, 32'd1);
        check("post_reset_rx_idle", {30'd0, dut.rx_state_q}, {30'd0, RxIdle});

        // Single byte 0x41 at full rate: latency and exact bit waveform
        frame = {1'b1, 8'h41, 1'b0};
        fork
            send_frame(1'b0, 8'h41, 1'b1, 50);
            begin
                wait_fall(1'b0, 12 * SlowBit, got, t);
                check("single_tx_started", {31'd0, got}, 32'd1);
                check("single_latency_ok",
                      {31'd0, (t - last_stop_cyc >= 218) && (t - last_stop_cyc <= 226)}, 32'd1);
                errs = 0;
                for (int k = 0; k < 10 * SlowBit; k++) begin
                    if (txd !== frame[k / SlowBit]) errs++;
                    @(negedge clk);
                end
                check("single_waveform_errors", errs, 32'd0);
                check("single_idle_after", {31'd0, txd}, 32'd1);
            end
        join

        // Table-driven single frames, including framing errors
        foreach (vecs[i]) begin
            fork
                send_frame(vecs[i].fast, vecs[i].data, vecs[i].stop, 5);
                recv_frame(vecs[i].fast, 12 * (vecs[i].fast ? FastBit : SlowBit), d, got, ok, t);
            join
            check($sformatf("vec%0d_echo_present", i), {31'd0, got}, {31'd0, vecs[i].echo});
            if (vecs[i].echo) begin
                check($sformatf("vec%0d_data", i), {24'd0, d}, {24'd0, vecs[i].data});
                check($sformatf("vec%0d_framing", i), {31'd0, ok}, 32'd1);
            end
            check($sformatf("vec%0d_fifo_empty", i),
                  {31'd0, vecs[i].fast ? dut_fast.u_fifo.empty : dut.u_fifo.empty}, 32'd1);
        end

        // Glitch: 2 us low pulse rejected at start mid-bit
        rxd = 1'b0;
        repeat (100) @(negedge clk);
        rxd = 1'b1;
        wait_fall(1'b0, 1000, got, t);
        check("glitch_no_tx", {31'd0, got}, 32'd0);
        check("glitch_fifo_empty", {31'd0, dut.u_fifo.empty}, 32'd1);
        check("glitch_rx_idle", {30'd0, dut.rx_state_q}, {30'd0, RxIdle});

        // Burst of ten on the fast instance, occupancy tracked
        max_occ = 0;
        occ_mon = 1'b1;
        fork
            for (int i = 0; i < 10; i++) send_frame(1'b1, 8'h41 + 8'(i), 1'b1, 3);
            for (int i = 0; i < 10; i++) begin
                recv_frame(1'b1, 12 * FastBit, d, got, ok, t);
                check($sformatf("burst%0d_got", i), {31'd0, got & ok}, 32'd1);
                check($sformatf("burst%0d_data", i), {24'd0, d}, {24'd0, 8'h41 + 8'(i)});
            end
        join
        occ_mon = 1'b0;
        @(negedge clk);
        check("burst_occupancy_le2", {31'd0, max_occ <= 2}, 32'd1);

        // Overflow: TX stalled while 18 frames arrive
        force dut_fast.tx_state_q = TxStop;
        for (int i = 0; i < 18; i++) send_frame(1'b1, 8'h60 + 8'(i), 1'b1, 2);
        check("ovf_count", {27'd0, occ}, 32'd16);
        check("ovf_full", {31'd0, dut_fast.u_fifo.full}, 32'd1);
        release dut_fast.tx_state_q;
        gap_bad = 0;
        t_prev = 0;
        for (int i = 0; i < 16; i++) begin
            recv_frame(1'b1, 12 * FastBit, d, got, ok, t);
            rx_bytes[i] = got && ok ? d : 8'hxx;
            if (i > 0 && (t - t_prev < 200 || t - t_prev > 201)) gap_bad++;
            t_prev = t;
        end
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovf%0d_data", i), {24'd0, rx_bytes[i]}, {24'd0, 8'h60 + 8'(i)});
        end
        check("ovf_back_to_back", gap_bad, 32'd0);
        recv_frame(1'b1, 12 * FastBit, d, got, ok, t);
        check("ovf_no_extra_frame", {31'd0, got}, 32'd0);
        check("ovf_fifo_empty", {31'd0, dut_fast.u_fifo.empty}, 32'd1);

        // Reset in the middle of a TX frame of 0x00 (line low during data bits)
        fork
            send_frame(1'b0, 8'h00, 1'b1, 0);
            wait_fall(1'b0, 12 * SlowBit, got, t);
        join
        check("rst_mid_tx_started", {31'd0, got}, 32'd1);
        repeat (1500) @(negedge clk);
        check("rst_mid_line_low", {31'd0, txd}, 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_txd_async", {31'd0, txd}, 32'd1);
        check("rst_mid_fifo_empty", {31'd0, dut.u_fifo.empty}, 32'd1);
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        errs = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (txd !== 1'b1) errs++;
        end
        check("rst_mid_no_output", errs, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
